// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin shared 8-bit binary to BCD converter (shift-add-3)
module bcd_conv_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] bin_in,
    input  logic              en_time,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic              done,
    output logic [2:0]        done_id,
    output logic [3:0]        hun,
    output logic [3:0]        ten,
    output logic [3:0]        one
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [7:0] sr;
    logic [3:0] d_h, d_t, d_o, h3, t3, o3;
    logic [2:0] cnt, last, gid, g, idx;
    logic [NREQ-1:0] rs;
    always_comb begin
        g = '0;
        idx = '0;
        rs = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = 3'((int'(last) + k) % NREQ);
            rs = req >> idx;
            g = rs[0] ? idx : g;
        end
        g = (en_time && req[0]) ? 3'd0 : g;
    end
    always_comb begin
        h3 = d_h >= 4'd5 ? d_h + 4'd3 : d_h;
        t3 = d_t >= 4'd5 ? d_t + 4'd3 : d_t;
        o3 = d_o >= 4'd5 ? d_o + 4'd3 : d_o;
        state_n = state == IDLE  ? (|req ? SHIFT : IDLE) :
                  state == SHIFT ? (cnt == 3'd7 ? DONE : SHIFT) : IDLE;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ack <= '0;
            done <= 1'b0;
            done_id <= '0;
            hun <= '0;
            ten <= '0;
            one <= '0;
            sr <= '0;
            d_h <= '0;
            d_t <= '0;
            d_o <= '0;
            cnt <= '0;
            gid <= '0;
            last <= 3'(NREQ - 1);
        end else begin
            state <= state_n;
            ack <= '0;
            done <= 1'b0;
            if (state == IDLE && |req) begin
                ack <= NREQ'(1) << g;
                sr <= 8'(bin_in >> {g, 3'b000});
                d_h <= '0;
                d_t <= '0;
                d_o <= '0;
                cnt <= '0;
                gid <= g;
                last <= g;
            end
            if (state == SHIFT) begin
                {d_h, d_t, d_o, sr} <= {h3, t3, o3, sr} << 1;
                cnt <= cnt + 3'd1;
            end
            if (state == DONE) begin
                hun <= d_h;
                ten <= d_t;
                one <= d_o;
                done <= 1'b1;
                done_id <= gid;
            end
        end
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed checks of arbitration, timing and BCD results
module tb_bcd_conv_arbiter;
    localparam int NREQ = 4;
    logic clk = 1'b0, rst = 1'b1, en_time = 1'b0, busy, done;
    logic [3:0] req = '0, ack, hun, ten, one;
    logic [31:0] bin_in = '0;
    logic [2:0] done_id;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    bcd_conv_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .en_time(en_time),
        .ack(ack), .busy(busy), .done(done), .done_id(done_id),
        .hun(hun), .ten(ten), .one(one)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    // Called just before the grant edge; returns one cycle after the result edge.
    task automatic expect_conv(input string tag, input logic [3:0] eack, input logic [2:0] eid,
                               input int ev, input bit drop);
        bit quiet;
        quiet = 1'b1;
        tick;
        check({tag, " ack"}, 32'(ack), 32'(eack));
        check({tag, " busy"}, 32'(busy), 1);
        if (drop) req = '0;
        repeat (8) begin
            tick;
            if (done !== 1'b0 || busy !== 1'b1 || ack !== 4'd0) quiet = 1'b0;
        end
        check({tag, " shifting"}, 32'(quiet), 1);
        tick;
        check({tag, " done"}, 32'(done), 1);
        check({tag, " busy_low"}, 32'(busy), 0);
        check({tag, " id"}, 32'(done_id), 32'(eid));
        check({tag, " hun"}, 32'(hun), ev / 100);
        check({tag, " ten"}, 32'(ten), (ev / 10) % 10);
        check({tag, " one"}, 32'(one), ev % 10);
    endtask
    initial begin
        bit seen;
        req = 4'($urandom);
        bin_in = $urandom;
        en_time = 1'($urandom);
        tick;
        req = 4'($urandom);
        tick;
        check("rst ack", 32'(ack), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst id", 32'(done_id), 0);
        check("rst digits", {20'd0, hun, ten, one}, 0);
        rst = 1'b0;
        en_time = 1'b0;
        req = 4'hf;
        bin_in = {8'd199, 8'd100, 8'd9, 8'd0};
        expect_conv("rr0", 4'b0001, 3'd0, 0, 1'b0);
        expect_conv("rr1", 4'b0010, 3'd1, 9, 1'b0);
        expect_conv("rr2", 4'b0100, 3'd2, 100, 1'b0);
        expect_conv("rr3", 4'b1000, 3'd3, 199, 1'b0);
        expect_conv("rr4", 4'b0001, 3'd0, 0, 1'b0);
        req = 4'b0010;
        bin_in = {8'd0, 8'd0, 8'd255, 8'd0};
        expect_conv("single", 4'b0010, 3'd1, 255, 1'b1);
        tick;
        check("hold hun", 32'(hun), 2);
        check("idle busy", 32'(busy), 0);
        req = 4'b0001;
        bin_in = {8'd0, 8'd0, 8'd0, 8'd42};
        expect_conv("pre_en", 4'b0001, 3'd0, 42, 1'b1);
        req = 4'b0111;
        en_time = 1'b1;
        bin_in = {8'd0, 8'd50, 8'd77, 8'd5};
        expect_conv("en0", 4'b0001, 3'd0, 5, 1'b0);
        expect_conv("en1", 4'b0001, 3'd0, 5, 1'b0);
        expect_conv("en2", 4'b0001, 3'd0, 5, 1'b0);
        en_time = 1'b0;
        expect_conv("rs1", 4'b0010, 3'd1, 77, 1'b0);
        expect_conv("rs2", 4'b0100, 3'd2, 50, 1'b1);
        req = 4'b0001;
        bin_in = {24'd0, 8'd137};
        tick;
        check("mid ack", 32'(ack), 1);
        req = '0;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid rst ack", 32'(ack), 0);
        check("mid rst busy", 32'(busy), 0);
        check("mid rst id", 32'(done_id), 0);
        check("mid rst digits", {20'd0, hun, ten, one}, 0);
        seen = 1'b0;
        repeat (10) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick;
        end
        check("mid no done", 32'(seen), 0);
        req = 4'b0001;
        expect_conv("after_rst", 4'b0001, 3'd0, 137, 1'b1);
        for (int v = 0; v < 256; v++) begin
            req = 4'b0001;
            bin_in = {24'd0, 8'(v)};
            expect_conv($sformatf("ex%0d", v), 4'b0001, 3'd0, v, 1'b1);
            check($sformatf("ex%0d range", v), 32'(hun <= 4'd2 && ten <= 4'd9 && one <= 4'd9), 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Time-shared binary-to-BCD conversion controller for the watch display path. Up to NREQ requesters (seconds, minutes, hours and alarm counters) each present an 8-bit binary value. The block arbitrates round-robin, with a time-setting override, and runs one iterative shift-add-3 conversion of 8 cycles per grant. It returns hundreds/tens/ones digits tagged with the requester id, so one converter serves all display fields.

## Interface
- NREQ, 4: number of requesters, legal 2..8; ids are 0..NREQ-1.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req  in  NREQ  per-requester conversion request, level.
- bin_in  in  8*NREQ  binary values; requester i uses bits [8i+7:8i].
- en_time  in  1  time-setting mode; when 1, requester 0 wins over all others.
- ack  out  NREQ  one-hot, 1-cycle pulse marking the cycle after the grant edge.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  1-cycle pulse; hun/ten/one/done_id are updated in the same cycle.
- done_id  out  3  id of the requester whose result is on hun/ten/one.
- hun, ten, one  out  4 each  BCD digits of the last completed conversion; held until the next done.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset values: ack=0, busy=0, done=0, done_id=0, hun=ten=one=0, state=IDLE, rr pointer last=NREQ-1, cnt=0.
- IDLE behaviour:
  - If req is nonzero at an edge: choose grant g, assert ack[g], latch bin_in[g] into an 8-bit shift register, clear internal digits and cnt, latch g, and go to SHIFT.
  - If req is zero, stay in IDLE.
- Arbitration:
  - If en_time=1 and req[0]=1, then g=0.
  - Otherwise g is the first asserted req scanning last+1, last+2, … modulo NREQ.
  - last<=g on every grant, including en_time overrides.
- SHIFT behaviour, each edge:
  - Add 3 to each internal digit that is ≥5.
  - Then shift {hun,ten,one,sr} left by one; the sr MSB enters one[0].
  - cnt increments. On the edge where cnt==7, go to DONE.
- DONE behaviour, one edge:
  - hun/ten/one are loaded from the internal digits, done<=1, done_id<=g, state<=IDLE.
- Digit ranges: hun 0..2, ten 0..9, one 0..9 for inputs 0..255; no other codes are legal.
- Requester contract:
  - Hold req and bin_in stable until ack is seen.
  - Drop req in the ack cycle if only one conversion is wanted.
  - req still high when the block returns to IDLE is a new request.
- req changes during SHIFT/DONE: ignored; sampled only in IDLE.
- bin_in changes after the grant edge: no effect on the running conversion.
- rst asserted mid-conversion: abandon immediately; no done pulse; all outputs return to their reset values.

## Timing
- Grant edge E0 (state IDLE, req≠0) → ack high during cycle E0..E1; busy high from E0.
- Shift edges E1..E8 → DONE is entered at E8.
- Result edge E9 → done, hun/ten/one and done_id are valid during cycle E9..E10; busy low in the same cycle.
- A new grant is possible at E10 at the earliest, giving a 10-cycle period per conversion.
- done and ack never overlap: at most one conversion is in flight.
- hun/ten/one change only on a done edge or on rst.

## Test plan
- Reset: assert rst for 2 cycles during random activity → all outputs 0, busy=0. First grant after release goes to req0 when req=4'b1111.
- Single request: req=4'b0010, bin_in[15:8]=8'd255 → ack=4'b0010 one cycle after the grant edge; done nine cycles later with hun=2, ten=5, one=5, done_id=1.
- Round-robin: req=4'b1111 held, values 0, 9, 100, 199 → done_id sequence 0,1,2,3,0 at 10-cycle spacing; digits (0,0,0), (0,0,9), (1,0,0), (1,9,9).
- en_time override: last grant=0, req=4'b0111, en_time=1 → next grants 0,0,0 while en_time stays 1. With en_time=0 the order resumes at 1, then 2.
- Reset mid-operation: rst at edge E4 of a conversion of 8'd137 → no done pulse, outputs 0. A fresh request for 8'd137 then yields hun=1, ten=3, one=7.
- Exhaustive: req0 only, bin 0..255 in sequence → each done matches a decimal reference; hun is never >2 and ten/one are never >9.
